// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock, with special-case results for divide-by-zero and signed overflow.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend_op,
    input  logic [WIDTH-1:0] divisor_op,
    input  logic [1:0]       DIVop,
    input  logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        PREP = 5'b00010,
        CALC = 5'b00100,
        FIX  = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [1:0]       op_reg;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             special;

    logic             is_signed;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic             special_c;
    logic [WIDTH+1:0] trial;

    assign is_signed = ~op_reg[0];
    assign abs_a_c   = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    assign abs_b_c   = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    assign special_c = (b_reg == '0) || (is_signed && a_reg == MIN_NEG && b_reg == '1);

    // Trial subtraction is one bit wider than the remainder so its sign bit tells
    // whether the shifted remainder was at least the divisor.
    assign trial = {rem, quo[WIDTH-1]} - {2'b00, abs_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b0;
            result  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            abs_b   <= '0;
            quo     <= '0;
            rem     <= '0;
            op_reg  <= '0;
            cnt     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            special <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b0;
                    if (valid) begin
                        a_reg  <= dividend_op;
                        b_reg  <= divisor_op;
                        op_reg <= DIVop;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    quo     <= abs_a_c;
                    abs_b   <= abs_b_c;
                    rem     <= '0;
                    cnt     <= CW'(WIDTH - 1);
                    q_neg   <= is_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    r_neg   <= is_signed & a_reg[WIDTH-1];
                    special <= special_c;
                    state   <= special_c ? FIX : CALC;
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        rem <= trial[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-1:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero and overflow results follow the RISC-V definitions.
                    if (special) begin
                        if (b_reg == '0) begin
                            result <= op_reg[1] ? a_reg : '1;
                        end else begin
                            result <= op_reg[1] ? '0 : MIN_NEG;
                        end
                    end else if (op_reg[1]) begin
                        result <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end else begin
                        result <= q_neg ? -quo : quo;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (valid) begin
                        ready <= 1'b1;
                    end else begin
                        ready <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ready <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
